i2c_slave_datapath: RTL
=======================

Name: i2c_slave_datapath

Overview:
- Bit-level datapath companion to the I2C slave control FSM; consumes the FSM's shift/load/ack strobes.
- Captures SDA into address, RW and write-data shift registers and decodes the device address.
- Serialises read data and drives SDA low for ACK and read bits.
- Owns the 8-bit register pointer and the register-file write strobe; returns addr_ack, data_ack, wr_mode, rd_mode and id_mode to the FSM.

Parameters:
DEV_ADDR, 7'h50, slave address for register access
ID_ADDR, 7'h7C, identification address; reads return ID_VALUE and writes are ACKed but discarded
ID_VALUE, 8'hA5, byte returned on every read in id_mode

Ports:
SCL  input  1  clock; rising edge samples SDA, falling edge updates all other state
POR  input  1  asynchronous reset, active-high
sda_in  input  1  synchronised SDA line level
s_detect  input  1  start condition seen
p_detect  input  1  stop condition seen
addr_reg_sen  input  1  FSM: shift address bit
rwb_reg_sen  input  1  FSM: capture RW bit
din_reg_sen  input  1  FSM: shift write-data bit
dout_reg_sen  input  1  FSM: read-data bit phase
dout_reg_len  input  1  FSM: parallel-load read byte
addr_end  input  1  FSM: RW bit phase
data_end  input  1  FSM: 8th data bit phase
addr_inc  input  1  FSM: data ACK phase
op_en  input  1  FSM: slave may drive SDA
reg_rdata  input  8  register-file read data at reg_addr (combinational)
addr_ack  output  1  address match (DEV_ADDR or ID_ADDR)
data_ack  output  1  continue after data byte
wr_mode  output  1  matched and RW=0
rd_mode  output  1  matched and RW=1
id_mode  output  1  matched address is ID_ADDR
reg_addr  output  8  register pointer
reg_wdata  output  8  write byte
reg_we  output  1  register write strobe, one SCL period
sda_oe  output  1  1 = pull SDA low

Behaviour:
- Reset (POR=1, asynchronous): all registers clear; reg_addr=0, reg_we=0, sda_oe=0, modes=0, addr_ack=0.

Rising SCL:
- addr_reg_sen: addr_sr <= {addr_sr[5:0], sda_in}.
- rwb_reg_sen: rwb <= sda_in; mode_vld <= 1.
- din_reg_sen: din_sr <= {din_sr[6:0], sda_in}.
- addr_inc & rd_mode: mack <= ~sda_in.

Address decode and modes:
- addr_ack = (addr_sr==DEV_ADDR) | (addr_sr==ID_ADDR), combinational.
- id_mode = mode_vld & (addr_sr==ID_ADDR).
- wr_mode = mode_vld & addr_ack & ~rwb.
- rd_mode = mode_vld & addr_ack & rwb.

Falling SCL:
- p_detect or s_detect clears mode_vld, ptr_phase, mack, reg_we. reg_addr is retained.
- addr_end sets ptr_phase=1.
- data_end & wr_mode:
  - if ptr_phase: reg_addr <= din_sr, ptr_phase <= 0.
  - else: reg_wdata <= din_sr; reg_we <= ~id_mode.
- reg_we is high for exactly one period, during the ACK phase. At the falling edge that ends it: reg_we <= 0 and reg_addr <= reg_addr+1.
- data_end & rd_mode: reg_addr <= reg_addr+1, so reg_rdata reflects the next byte during the ACK phase.
- reg_addr increments wrap 8'hFF -> 8'h00.
- dout_reg_len: dout_sr <= id_mode ? ID_VALUE : reg_rdata. Load has priority over shift.
- dout_reg_sen: dout_sr <= {dout_sr[6:0],1'b0}. MSB first; the bit changes only while SCL is low.
- mack clears on every falling edge where addr_inc=0.

SDA drive and data ACK:
- data_ack = wr_mode | (rd_mode & mack).
- sda_oe = op_en & (dout_reg_sen ? ~dout_sr[7] : (addr_inc ? wr_mode : addr_ack)).
- Net effect: ACK on address match; ACK after every write byte; drive read bits; release for master ACK on reads.
- No match: sda_oe stays 0 throughout; reg_we is never asserted.

Repeated start and stop:
- Repeated start clears modes; reg_addr persists, so write-pointer-then-repeated-start-read works.
- A stop in the middle of a byte discards the partial din_sr and produces no write.
- Reset mid-transfer releases SDA immediately.

Test Plan:
1. Write 0xA0, 0x10, 0x3C, 0x7E, stop -> ACK on all 4 bytes. reg_addr=0x10 after byte 2. reg_we pulses with 0x3C @0x10, then 0x7E @0x11. Final reg_addr=0x12.
2. Write 0xA0, 0x20; repeated start; 0xA1; read 3 bytes (master ACK, ACK, NACK) with regs[0x20..0x22]=0x11,0x22,0x33 -> SDA bits 0x11,0x22,0x33 MSB-first. data_ack=0 after byte 3. reg_addr=0x23.
3. Address 0x42 (non-matching) -> addr_ack=0, sda_oe never 1, no reg_we.
4. Pointer 0xFF, write 2 data bytes -> writes land at 0xFF then 0x00.
5. 0xF9 (ID read) -> returns 0xA5. ID write 0xF8, 0x05, 0x99 -> ACKed, no reg_we.
6. Stop after 4 data bits of a write byte, then POR pulse while sda_oe=1 -> no write; sda_oe drops asynchronously; reg_addr=0.

Source files
------------

// File: rtl/i2c_slave_datapath.sv
// Bit-level I2C slave datapath: SDA capture and address decode on rising SCL,
// register pointer, write strobe and read serialiser on falling SCL.
module i2c_slave_datapath #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter logic [6:0] ID_ADDR  = 7'h7C,
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic       SCL,
  input  logic       POR,
  input  logic       sda_in,
  input  logic       s_detect,
  input  logic       p_detect,
  input  logic       addr_reg_sen,
  input  logic       rwb_reg_sen,
  input  logic       din_reg_sen,
  input  logic       dout_reg_sen,
  input  logic       dout_reg_len,
  input  logic       addr_end,
  input  logic       data_end,
  input  logic       addr_inc,
  input  logic       op_en,
  input  logic [7:0] reg_rdata,
  output logic       addr_ack,
  output logic       data_ack,
  output logic       wr_mode,
  output logic       rd_mode,
  output logic       id_mode,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       sda_oe
);

  // Rising-edge state
  logic [6:0] addr_sr;
  logic       rwb;
  logic [7:0] din_sr;
  logic       mode_set;
  logic       mack_set;
  logic       mack_val;

  // Falling-edge state
  logic       mode_clr;
  logic       mack_clr;
  logic       ptr_phase;
  logic [7:0] dout_sr;

  logic       mode_vld;
  logic       mack;
  logic       start_stop;

  function automatic logic [7:0] ptr_next(input logic [7:0] ptr);
    ptr_next = ptr + 8'd1;
  endfunction

  // mode_vld and mack are set on rising SCL but cleared on falling SCL; each is
  // split into a set/clear flag pair so every flop has a single clock edge.
  assign mode_vld   = mode_set ^ mode_clr;
  assign mack       = (mack_set ^ mack_clr) & mack_val;
  assign start_stop = s_detect | p_detect;

  assign addr_ack = (addr_sr == DEV_ADDR) | (addr_sr == ID_ADDR);
  assign id_mode  = mode_vld & (addr_sr == ID_ADDR);
  assign wr_mode  = mode_vld & addr_ack & ~rwb;
  assign rd_mode  = mode_vld & addr_ack & rwb;
  assign data_ack = wr_mode | (rd_mode & mack);

  always_comb begin
    sda_oe = 1'b0;
    if (op_en) begin
      if (dout_reg_sen)
        sda_oe = ~dout_sr[7];
      else if (addr_inc)
        sda_oe = wr_mode;
      else
        sda_oe = addr_ack;
    end
  end

  // Stage boundary: SDA sampling on rising SCL
  always_ff @(posedge SCL or posedge POR) begin
    if (POR) begin
      addr_sr  <= '0;
      rwb      <= 1'b0;
      din_sr   <= '0;
      mode_set <= 1'b0;
      mack_set <= 1'b0;
      mack_val <= 1'b0;
    end else begin
      if (addr_reg_sen)
        addr_sr <= {addr_sr[5:0], sda_in};
      if (rwb_reg_sen) begin
        rwb      <= sda_in;
        mode_set <= ~mode_clr;
      end
      if (din_reg_sen)
        din_sr <= {din_sr[6:0], sda_in};
      if (addr_inc && rd_mode) begin
        mack_set <= ~mack_clr;
        mack_val <= ~sda_in;
      end
    end
  end

  // Stage boundary: pointer, write strobe and output shifter on falling SCL
  always_ff @(negedge SCL or posedge POR) begin
    if (POR) begin
      mode_clr  <= 1'b0;
      mack_clr  <= 1'b0;
      ptr_phase <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      dout_sr   <= '0;
    end else begin
      if (start_stop || !addr_inc)
        mack_clr <= mack_set;

      if (start_stop) begin
        mode_clr  <= mode_set;
        ptr_phase <= 1'b0;
        reg_we    <= 1'b0;
      end else begin
        if (reg_we) begin
          reg_we   <= 1'b0;
          reg_addr <= ptr_next(reg_addr);
        end
        if (addr_end)
          ptr_phase <= 1'b1;
        if (data_end && wr_mode) begin
          if (ptr_phase) begin
            reg_addr  <= din_sr;
            ptr_phase <= 1'b0;
          end else begin
            reg_wdata <= din_sr;
            reg_we    <= ~id_mode;
          end
        end
        // Advance early on reads so reg_rdata holds the next byte during ACK
        if (data_end && rd_mode)
          reg_addr <= ptr_next(reg_addr);
      end

      if (dout_reg_len)
        dout_sr <= id_mode ? ID_VALUE : reg_rdata;
      else if (dout_reg_sen)
        dout_sr <= {dout_sr[6:0], 1'b0};
    end
  end

endmodule
